// File: rtl/spy_buffer_mc.sv
// Multi-lane spy buffer: per-lane FWFT flow-control FIFO, circular spy memory and
// end-of-event list, plus a shared freeze FSM. Optional: SPY_BUFFER_MC_OVERFLOW_FREEZE_EN.

// Generic first-word-fall-through FIFO with almost-full level and drop indication.
// Latency: a pushed word is visible on rd_dat one edge after the write.
// Backpressure: no stall; a write while full without a same-cycle pop is dropped (drop=1).
module fifo_fwft #(
    parameter int WIDTH  = 65,
    parameter int AW     = 3,
    parameter int MARGIN = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic             empty,
    output logic             almost_full,
    output logic             drop
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AF_LVL   = (AW+1)'(DEPTH - MARGIN);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             push;
    logic             pop;

    assign full        = (count == FULL_LVL);
    assign empty       = (count == '0);
    assign almost_full = (count >= AF_LVL);
    assign pop         = rd_rdy && !empty;
    assign push        = wr_vld && (!full || pop);
    assign drop        = wr_vld && full && !pop;
    assign rd_dat      = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// Multi-channel spy buffer with shared freeze control and channel-selected spy readout.
// Latency: FIFO head one edge after write; spy/meta reads registered, one cycle.
// Backpressure: none; full-FIFO writes are dropped and flagged in sticky overflow.
module spy_buffer_mc #(
    parameter int NCHAN         = 2,
    parameter int DATA_WIDTH    = 64,
    parameter int FC_FIFO_WIDTH = 3,
    parameter int SPY_MEM_WIDTH = 7,
    parameter int EL_MEM_WIDTH  = 4,
    parameter int AFULL_MARGIN  = 2,
    parameter int DELAY_WIDTH   = 8,
    parameter int CSEL_WIDTH    = 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NCHAN*(DATA_WIDTH+1)-1:0]    write_data,
    input  logic [NCHAN-1:0]                   write_enable,
    input  logic [NCHAN-1:0]                   read_enable,
    output logic [NCHAN*(DATA_WIDTH+1)-1:0]    read_data,
    output logic [NCHAN-1:0]                   empty,
    output logic [NCHAN-1:0]                   almost_full,
    output logic [NCHAN-1:0]                   overflow,
    input  logic                               freeze,
    input  logic [DELAY_WIDTH-1:0]             freeze_delay,
    output logic                               frozen,
    input  logic [CSEL_WIDTH-1:0]              spy_chan_sel,
    input  logic                               spy_read_enable,
    input  logic [SPY_MEM_WIDTH-1:0]           spy_read_addr,
    output logic [DATA_WIDTH:0]                spy_data,
    output logic                               spy_data_valid,
    input  logic                               spy_meta_read_enable,
    input  logic [EL_MEM_WIDTH-1:0]            spy_meta_read_addr,
    output logic [SPY_MEM_WIDTH:0]             spy_meta_read_data,
    output logic                               spy_meta_valid,
    output logic [NCHAN*SPY_MEM_WIDTH-1:0]     spy_write_addr,
    output logic [NCHAN*EL_MEM_WIDTH-1:0]      spy_meta_write_addr,
    output logic [NCHAN-1:0]                   spy_wrapped
);
    localparam int WW        = DATA_WIDTH + 1;
    localparam int SPY_DEPTH = 1 << SPY_MEM_WIDTH;
    localparam int EL_DEPTH  = 1 << EL_MEM_WIDTH;
    localparam logic [SPY_MEM_WIDTH-1:0] SPY_ONE = SPY_MEM_WIDTH'(1);
    localparam logic [EL_MEM_WIDTH-1:0]  EL_ONE  = EL_MEM_WIDTH'(1);
    localparam logic [DELAY_WIDTH-1:0]   DLY_ONE = DELAY_WIDTH'(1);

    typedef enum logic [1:0] {ST_RUN, ST_ARMED, ST_FROZEN} state_t;

    state_t                 state;
    logic [DELAY_WIDTH-1:0] dly_cnt;
    logic                   capture_en;
    logic                   ovf_trig;
    logic [NCHAN-1:0]       lane_drop;
    logic [WW-1:0]          lane_spy_rd  [NCHAN];
    logic [SPY_MEM_WIDTH:0] lane_meta_rd [NCHAN];
    logic [WW-1:0]          sel_spy;
    logic [SPY_MEM_WIDTH:0] sel_meta;

`ifdef SPY_BUFFER_MC_OVERFLOW_FREEZE_EN
    logic ovf_lock;
    logic ovf_armed;
    assign ovf_trig = |lane_drop;
`else
    assign ovf_trig = 1'b0;
`endif

    // The trigger cycle itself is dropped from capture only for an immediate freeze.
    always_comb begin
        capture_en = 1'b0;
        case (state)
            ST_RUN:   capture_en = !(freeze && (freeze_delay == '0)) && !ovf_trig;
            ST_ARMED: capture_en = !ovf_trig;
            default:  capture_en = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_RUN;
            dly_cnt <= '0;
            frozen  <= 1'b0;
`ifdef SPY_BUFFER_MC_OVERFLOW_FREEZE_EN
            ovf_lock  <= 1'b0;
            ovf_armed <= 1'b0;
`endif
        end else begin
            case (state)
                ST_RUN: begin
                    if (ovf_trig || (freeze && (freeze_delay == '0))) begin
                        state  <= ST_FROZEN;
                        frozen <= 1'b1;
`ifdef SPY_BUFFER_MC_OVERFLOW_FREEZE_EN
                        ovf_lock  <= ovf_trig;
                        ovf_armed <= 1'b0;
`endif
                    end else if (freeze) begin
                        state   <= ST_ARMED;
                        dly_cnt <= freeze_delay - DLY_ONE;
                    end
                end
                ST_ARMED: begin
                    if (ovf_trig || (freeze && (dly_cnt == '0))) begin
                        state  <= ST_FROZEN;
                        frozen <= 1'b1;
`ifdef SPY_BUFFER_MC_OVERFLOW_FREEZE_EN
                        ovf_lock  <= ovf_trig;
                        ovf_armed <= 1'b0;
`endif
                    end else if (!freeze) begin
                        state <= ST_RUN;
                    end else begin
                        dly_cnt <= dly_cnt - DLY_ONE;
                    end
                end
                default: begin
`ifdef SPY_BUFFER_MC_OVERFLOW_FREEZE_EN
                    // An overflow-induced freeze only releases after a full freeze pulse.
                    if (ovf_lock) begin
                        if (freeze) begin
                            ovf_armed <= 1'b1;
                        end else if (ovf_armed) begin
                            state     <= ST_RUN;
                            frozen    <= 1'b0;
                            ovf_lock  <= 1'b0;
                            ovf_armed <= 1'b0;
                        end
                    end else if (!freeze) begin
                        state  <= ST_RUN;
                        frozen <= 1'b0;
                    end
`else
                    if (!freeze) begin
                        state  <= ST_RUN;
                        frozen <= 1'b0;
                    end
`endif
                end
            endcase
        end
    end

    for (genvar c = 0; c < NCHAN; c++) begin : g_lane
        logic [WW-1:0]            wdat;
        logic                     cap;
        logic [WW-1:0]            spy_mem [SPY_DEPTH];
        logic [SPY_MEM_WIDTH-1:0] el_mem  [EL_DEPTH];
        logic [SPY_MEM_WIDTH-1:0] spy_ptr;
        logic [EL_MEM_WIDTH-1:0]  el_ptr;
        logic [EL_DEPTH-1:0]      el_valid;
        logic                     ovf;
        logic                     wrapped;

        assign wdat = write_data[c*WW +: WW];
        assign cap  = write_enable[c] && capture_en;

        fifo_fwft #(
            .WIDTH  (WW),
            .AW     (FC_FIFO_WIDTH),
            .MARGIN (AFULL_MARGIN)
        ) u_fifo (
            .clock       (clock),
            .reset       (reset),
            .wr_vld      (write_enable[c]),
            .wr_dat      (wdat),
            .rd_rdy      (read_enable[c]),
            .rd_dat      (read_data[c*WW +: WW]),
            .empty       (empty[c]),
            .almost_full (almost_full[c]),
            .drop        (lane_drop[c])
        );

        always_ff @(posedge clock) begin
            if (cap) begin
                spy_mem[spy_ptr] <= wdat;
                if (wdat[DATA_WIDTH]) begin
                    el_mem[el_ptr] <= spy_ptr;
                end
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                spy_ptr  <= '0;
                el_ptr   <= '0;
                el_valid <= '0;
                ovf      <= 1'b0;
                wrapped  <= 1'b0;
            end else begin
                if (lane_drop[c]) begin
                    ovf <= 1'b1;
                end
                if (cap) begin
                    spy_ptr <= spy_ptr + SPY_ONE;
                    if (&spy_ptr) begin
                        wrapped <= 1'b1;
                    end
                    if (wdat[DATA_WIDTH]) begin
                        el_valid[el_ptr] <= 1'b1;
                        el_ptr           <= el_ptr + EL_ONE;
                    end
                end
            end
        end

        assign lane_spy_rd[c]  = spy_mem[spy_read_addr];
        assign lane_meta_rd[c] = {el_valid[spy_meta_read_addr], el_mem[spy_meta_read_addr]};

        assign overflow[c]                                   = ovf;
        assign spy_wrapped[c]                                = wrapped;
        assign spy_write_addr[c*SPY_MEM_WIDTH +: SPY_MEM_WIDTH]     = spy_ptr;
        assign spy_meta_write_addr[c*EL_MEM_WIDTH +: EL_MEM_WIDTH]  = el_ptr;
    end

    // An out-of-range channel matches no lane and therefore reads as zero.
    always_comb begin
        sel_spy  = '0;
        sel_meta = '0;
        for (int c = 0; c < NCHAN; c++) begin
            if (32'(spy_chan_sel) == c) begin
                sel_spy  = lane_spy_rd[c];
                sel_meta = lane_meta_rd[c];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            spy_data           <= '0;
            spy_data_valid     <= 1'b0;
            spy_meta_read_data <= '0;
            spy_meta_valid     <= 1'b0;
        end else begin
            spy_data_valid <= spy_read_enable;
            spy_meta_valid <= spy_meta_read_enable;
            if (spy_read_enable) begin
                spy_data <= sel_spy;
            end
            if (spy_meta_read_enable) begin
                spy_meta_read_data <= sel_meta;
            end
        end
    end
endmodule

// File: tb/tb_spy_buffer_mc.sv
// Directed self-checking bench for spy_buffer_mc (default build, two lanes).
module tb_spy_buffer_mc;
    logic         clock = 1'b0;
    logic         reset;
    logic [129:0] write_data;
    logic [1:0]   write_enable;
    logic [1:0]   read_enable;
    logic [129:0] read_data;
    logic [1:0]   empty;
    logic [1:0]   almost_full;
    logic [1:0]   overflow;
    logic         freeze;
    logic [7:0]   freeze_delay;
    logic         frozen;
    logic [0:0]   spy_chan_sel;
    logic         spy_read_enable;
    logic [6:0]   spy_read_addr;
    logic [64:0]  spy_data;
    logic         spy_data_valid;
    logic         spy_meta_read_enable;
    logic [3:0]   spy_meta_read_addr;
    logic [7:0]   spy_meta_read_data;
    logic         spy_meta_valid;
    logic [13:0]  spy_write_addr;
    logic [7:0]   spy_meta_write_addr;
    logic [1:0]   spy_wrapped;

    int total = 0;
    int bad   = 0;

    spy_buffer_mc dut (
        .clock                (clock),
        .reset                (reset),
        .write_data           (write_data),
        .write_enable         (write_enable),
        .read_enable          (read_enable),
        .read_data            (read_data),
        .empty                (empty),
        .almost_full          (almost_full),
        .overflow             (overflow),
        .freeze               (freeze),
        .freeze_delay         (freeze_delay),
        .frozen               (frozen),
        .spy_chan_sel         (spy_chan_sel),
        .spy_read_enable      (spy_read_enable),
        .spy_read_addr        (spy_read_addr),
        .spy_data             (spy_data),
        .spy_data_valid       (spy_data_valid),
        .spy_meta_read_enable (spy_meta_read_enable),
        .spy_meta_read_addr   (spy_meta_read_addr),
        .spy_meta_read_data   (spy_meta_read_data),
        .spy_meta_valid       (spy_meta_valid),
        .spy_write_addr       (spy_write_addr),
        .spy_meta_write_addr  (spy_meta_write_addr),
        .spy_wrapped          (spy_wrapped)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_wr(input int c, input logic en, input logic [64:0] w);
        write_data[c*65 +: 65] = w;
        write_enable[c]        = en;
    endtask

    initial begin
        logic eoe;
        reset = 1'b0; write_data = '0; write_enable = '0; read_enable = '0;
        freeze = 1'b0; freeze_delay = '0; spy_chan_sel = '0;
        spy_read_enable = 1'b0; spy_read_addr = '0;
        spy_meta_read_enable = 1'b0; spy_meta_read_addr = '0;
        #23;
        chk("rst_empty", empty, 2'b11);
        chk("rst_afull", almost_full, 2'b00);
        chk("rst_ovf", overflow, 2'b00);
        chk("rst_frozen", frozen, 1'b0);
        chk("rst_wrapped", spy_wrapped, 2'b00);
        chk("rst_spy_waddr", spy_write_addr, 14'd0);
        chk("rst_meta_waddr", spy_meta_write_addr, 8'd0);
        chk("rst_spy_data", {spy_data_valid, spy_data}, 66'd0);
        chk("rst_meta_data", {spy_meta_valid, spy_meta_read_data}, 9'd0);
        tick();
        reset = 1'b1;

        // Lane 0 fill to overflow.
        for (int i = 1; i <= 9; i++) begin
            set_wr(0, 1'b1, 65'(i));
            tick();
            if (i == 1) chk("l0_head_first", read_data[64:0], 65'd1);
            if (i == 5) chk("l0_afull_at5", almost_full[0], 1'b0);
            if (i == 6) chk("l0_afull_at6", almost_full[0], 1'b1);
            if (i == 8) chk("l0_ovf_at8", overflow[0], 1'b0);
            if (i == 9) chk("l0_ovf_at9", overflow[0], 1'b1);
        end
        set_wr(0, 1'b0, '0);
        chk("l0_spy_ptr9", spy_write_addr[6:0], 7'd9);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("l0_pop%0d", i), read_data[64:0], 65'(i));
            read_enable = 2'b01;
            tick();
        end
        read_enable = 2'b00;
        chk("l0_empty_after_pops", empty[0], 1'b1);

        spy_chan_sel = 1'b0; spy_read_addr = 7'd8; spy_read_enable = 1'b1;
        tick();
        spy_read_enable = 1'b0;
        chk("spy_rd_dropped_word", {spy_data_valid, spy_data}, {1'b1, 65'd9});
        tick();
        chk("spy_rd_hold", {spy_data_valid, spy_data}, {1'b0, 65'd9});

        // Lane 1 simultaneous write/read while empty, then while full.
        set_wr(1, 1'b1, 65'h0AA); read_enable = 2'b10;
        tick();
        read_enable = 2'b00;
        chk("l1_wr_rd_empty", {empty[1], read_data[129:65]}, {1'b0, 65'h0AA});
        for (int j = 1; j <= 7; j++) begin
            set_wr(1, 1'b1, 65'(8'hB0 + j));
            tick();
        end
        chk("l1_afull_full", almost_full[1], 1'b1);
        set_wr(1, 1'b1, 65'h0C0); read_enable = 2'b10;
        tick();
        read_enable = 2'b00;
        chk("l1_full_wr_rd_ovf", overflow[1], 1'b0);
        chk("l1_full_wr_rd_head", read_data[129:65], 65'h0B1);
        set_wr(1, 1'b1, 65'h0C1);
        tick();
        set_wr(1, 1'b0, '0);
        chk("l1_still_full", overflow[1], 1'b1);

        reset = 1'b0;
        #1;
        chk("rst2_ovf", overflow, 2'b00);
        tick();
        reset = 1'b1;

        // Lane 1: 200 words, EOE on every 10th.
        for (int i = 0; i < 200; i++) begin
            eoe = ((i % 10) == 9);
            set_wr(1, 1'b1, {eoe, 64'(i)});
            tick();
        end
        set_wr(1, 1'b0, '0);
        chk("l1_spy_ptr72", spy_write_addr[13:7], 7'd72);
        chk("l0_spy_ptr0", spy_write_addr[6:0], 7'd0);
        chk("wrapped", spy_wrapped, 2'b10);
        chk("meta_waddr", spy_meta_write_addr, {4'd4, 4'd0});
        spy_chan_sel = 1'b1;
        spy_meta_read_addr = 4'd3; spy_meta_read_enable = 1'b1;
        spy_read_addr = 7'd71; spy_read_enable = 1'b1;
        tick();
        spy_meta_read_enable = 1'b0; spy_read_enable = 1'b0;
        chk("meta_slot3", {spy_meta_valid, spy_meta_read_data}, {1'b1, 8'hC7});
        chk("spy_addr71", {spy_data_valid, spy_data}, {1'b1, 1'b1, 64'd199});
        spy_meta_read_addr = 4'd7; spy_meta_read_enable = 1'b1;
        spy_read_addr = 7'd72; spy_read_enable = 1'b1;
        tick();
        spy_meta_read_enable = 1'b0; spy_read_enable = 1'b0;
        chk("meta_slot7", spy_meta_read_data, 8'hCF);
        chk("spy_addr72", spy_data, {1'b0, 64'd72});
        tick();
        chk("meta_valid_pulse", spy_meta_valid, 1'b0);

        // Delayed freeze on lane 0 with continuous writes.
        read_enable = 2'b01;
        for (int n = 0; n < 3; n++) begin
            set_wr(0, 1'b1, 65'(12'h100 + n));
            tick();
        end
        freeze = 1'b1; freeze_delay = 8'd5;
        for (int k = 0; k <= 8; k++) begin
            set_wr(0, 1'b1, 65'(12'h103 + k));
            tick();
            if (k == 0) freeze_delay = 8'd0;
            if (k == 4) chk("dly_k4", {frozen, spy_write_addr[6:0]}, {1'b0, 7'd8});
            if (k == 5) chk("dly_k5", {frozen, spy_write_addr[6:0]}, {1'b1, 7'd9});
            if (k == 8) chk("dly_k8", {frozen, spy_write_addr[6:0]}, {1'b1, 7'd9});
        end
        spy_chan_sel = 1'b0; spy_read_addr = 7'd8; spy_read_enable = 1'b1;
        freeze = 1'b0;
        set_wr(0, 1'b1, 65'h1FF);
        tick();
        spy_read_enable = 1'b0;
        chk("frozen_read", spy_data, 65'h108);
        chk("unfreeze", {frozen, spy_write_addr[6:0]}, {1'b0, 7'd9});
        set_wr(0, 1'b1, 65'h109);
        tick();
        chk("resume_capture", spy_write_addr[6:0], 7'd10);

        // Immediate freeze: trigger cycle not captured.
        freeze = 1'b1; freeze_delay = 8'd0;
        set_wr(0, 1'b1, 65'h1EE);
        tick();
        chk("imm_freeze", {frozen, spy_write_addr[6:0]}, {1'b1, 7'd10});
        tick();
        set_wr(0, 1'b0, '0);
        chk("frozen_hold", spy_write_addr[6:0], 7'd10);
        spy_read_addr = 7'd9; spy_read_enable = 1'b1;
        tick();
        spy_read_enable = 1'b0;
        chk("resume_word", spy_data, 65'h109);
        freeze = 1'b0;
        tick();
        chk("run_again", frozen, 1'b0);

        // Async reset while ARMED with data in both FIFOs.
        read_enable = 2'b00;
        freeze = 1'b1; freeze_delay = 8'd20;
        set_wr(0, 1'b1, 65'h55);
        set_wr(1, 1'b1, {1'b1, 64'h66});
        tick();
        tick();
        set_wr(0, 1'b0, '0); set_wr(1, 1'b0, '0);
        chk("armed_not_frozen", {frozen, empty}, 3'b000);
        #2;
        reset = 1'b0;
        #1;
        chk("async_empty", {empty, almost_full, overflow}, 6'b110000);
        chk("async_ptrs", {spy_write_addr, spy_meta_write_addr}, 22'd0);
        chk("async_flags", {frozen, spy_wrapped}, 3'b000);
        chk("async_spy_out", {spy_data_valid, spy_data}, 66'd0);
        tick();
        reset = 1'b1;
        freeze = 1'b1; freeze_delay = 8'd0;
        set_wr(0, 1'b1, 65'h77);
        tick();
        set_wr(0, 1'b0, '0);
        chk("fsm_run_after_rst", {frozen, spy_write_addr[6:0]}, {1'b1, 7'd0});
        freeze = 1'b0;
        tick();
        spy_chan_sel = 1'b1; spy_meta_read_addr = 4'd3; spy_meta_read_enable = 1'b1;
        tick();
        spy_meta_read_enable = 1'b0;
        chk("meta_valid_cleared", {spy_meta_valid, spy_meta_read_data[7]}, 2'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
